// File: rtl/fifo.sv
// rtl/fifo.sv - single-clock register-based FIFO with valid/ready on both sides
//
// First-word-fall-through queue: the head entry is presented combinationally
// on data_o whenever the FIFO holds data.
//
// Ports:
//   clk           in   clock, all state updates on the rising edge
//   nreset_i      in   asynchronous reset, active-high despite the name
//   data_i        in   write data
//   data_i_valid  in   producer offers data_i this cycle
//   data_i_ready  out  FIFO can accept a write (not full)
//   data_o        out  head-of-queue data
//   data_o_valid  out  data_o holds a valid entry (not empty)
//   data_o_ready  in   consumer takes data_o this cycle
module fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  nreset_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_i_valid,
  output logic                  data_i_ready,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_o_valid,
  input  logic                  data_o_ready
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  push, pop;

  // Handshake outputs come from registered state only, so there is no
  // combinational path from data_o_ready to data_i_ready.
  assign data_i_ready = (count_q != (ADDR_WIDTH+1)'(DEPTH));
  assign data_o_valid = (count_q != '0);
  assign data_o       = mem_q[rd_ptr_q];

  assign push = data_i_valid & data_i_ready;
  assign pop  = data_o_ready & data_o_valid;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = data_i;
      // Pointers wrap by natural overflow; DEPTH is a power of two.
      wr_ptr_d        = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge nreset_i) begin
    if (nreset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fifo.sv
// tb/tb_fifo.sv - self-checking bench for fifo against a queue reference model
module tb_fifo;

  localparam int DW = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          nreset_i;
  logic [DW-1:0] data_i;
  logic          data_i_valid;
  logic          data_i_ready;
  logic [DW-1:0] data_o;
  logic          data_o_valid;
  logic          data_o_ready;

  fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .nreset_i     (nreset_i),
    .data_i       (data_i),
    .data_i_valid (data_i_valid),
    .data_i_ready (data_i_ready),
    .data_o       (data_o),
    .data_o_valid (data_o_valid),
    .data_o_ready (data_o_ready)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] model_q[$];
  int n_pass = 0;
  int n_total = 0;
  int accepted;
  int popped;
  bit last_push;
  bit last_pop;
  logic [DW-1:0] last_pop_data;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: drive inputs, check outputs against the model mid-cycle,
  // then advance the model with whatever handshakes the rules allow.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r);
    bit push;
    bit pop;
    data_i_valid = v;
    data_i       = d;
    data_o_ready = r;
    #1;
    check("data_i_ready", {31'd0, data_i_ready}, {31'd0, model_q.size() != DEPTH});
    check("data_o_valid", {31'd0, data_o_valid}, {31'd0, model_q.size() != 0});
    if (model_q.size() != 0) check("data_o", data_o, model_q[0]);
    push = v && (model_q.size() != DEPTH);
    pop  = r && (model_q.size() != 0);
    last_pop_data = (model_q.size() != 0) ? model_q[0] : '0;
    @(posedge clk);
    if (pop) void'(model_q.pop_front());
    if (push) model_q.push_back(d);
    last_push = push;
    last_pop  = pop;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'd0, data_i_ready}, 32'd1);
    check({tag, "_out_valid"}, {31'd0, data_o_valid}, 32'd0);
    check({tag, "_data_o"}, data_o, 32'd0);
  endtask

  initial begin
    data_i = '0;
    data_i_valid = 1'b0;
    data_o_ready = 1'b0;
    nreset_i = 1'b1;
    #1;
    check_reset_outputs("during_reset");
    #1;
    nreset_i = 1'b0;
    #1;
    check_reset_outputs("after_reset");

    // Fill with constant 12 while consumer stalls.
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 32'd12, 1'b0);
      if (last_push) accepted++;
    end
    check("fill_accepted", accepted, DEPTH);

    // Drain: 12 on every cycle, then empty.
    popped = 0;
    for (int i = 0; i < 18; i++) begin
      cycle(1'b0, 32'd0, 1'b1);
      if (last_pop) begin
        popped++;
        check("drain_data", last_pop_data, 32'd12);
      end
    end
    check("drain_popped", popped, DEPTH);
    #1;
    check("drain_in_ready", {31'd0, data_i_ready}, 32'd1);
    check("drain_out_valid", {31'd0, data_o_valid}, 32'd0);

    // Partial drain/refill across the pointer wrap.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h100 + i, 1'b0);
    cycle(1'b0, 32'd0, 1'b1);
    cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b0, 32'd0, 1'b1);
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'h200 + i, 1'b0);
      if (last_push) accepted++;
    end
    check("refill_accepted", accepted, 2);
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, 32'd0, 1'b1);

    // Ordering 1..20 with consumer toggling every cycle.
    begin
      int next_val;
      int budget;
      next_val = 1;
      budget = 0;
      popped = 0;
      while ((next_val <= 20 || model_q.size() != 0) && budget < 200) begin
        cycle(next_val <= 20, next_val, budget[0]);
        if (last_push) next_val++;
        if (last_pop) begin
          popped++;
          check("order", last_pop_data, popped);
        end
        budget++;
      end
      check("order_done_in_budget", {31'd0, budget < 200}, 32'd1);
      check("order_popped", popped, 20);
    end

    // Full with simultaneous traffic: first cycle pops only, then 1-in/1-out.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h300 + i, 1'b0);
    cycle(1'b1, 32'h400, 1'b1);
    check("full_first_no_push", {31'd0, last_push}, 32'd0);
    check("full_first_pop", {31'd0, last_pop}, 32'd1);
    for (int i = 1; i < 8; i++) begin
      cycle(1'b1, 32'h400 + i, 1'b1);
      check("full_steady_pop", {31'd0, last_pop}, 32'd1);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 1), $urandom, $urandom_range(0, 1));
    end

    // Reset asserted mid-operation discards everything immediately.
    for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b0);
    nreset_i = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    model_q.delete();
    #1;
    nreset_i = 1'b0;
    #1;
    check_reset_outputs("mid_reset_release");
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'h500 + i, i[0]);
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
